// File: rtl/nco_pkg.sv
// Shared constants and phase-quadrant encoding for the NCO and the CORDIC rotator.
package nco_pkg;

  localparam int          NCO_WIDTH     = 32;
  localparam logic [31:0] NCO_X_INIT    = 32'h26DD3B6A;
  localparam int          NCO_DIV_WIDTH = 16;

  // Top two phase bits; the CORDIC quadrant pre-rotation uses the same encoding.
  typedef enum logic [1:0] {
    QUAD_RIGHT_POS   = 2'b00,
    QUAD_POS_HALF_PI = 2'b01,
    QUAD_NEG_HALF_PI = 2'b10,
    QUAD_RIGHT_NEG   = 2'b11
  } quadrant_e;

  function automatic quadrant_e quadrant_of(input logic [NCO_WIDTH-1:0] phase);
    return quadrant_e'(phase[NCO_WIDTH-1 -: 2]);
  endfunction

endpackage

// File: rtl/cordic_nco_source_if.sv
// Sample output bus towards the CORDIC rotator, valid/ready handshake.
interface cordic_nco_source_if
  import nco_pkg::*;
#(
  parameter int WIDTH = NCO_WIDTH
) ();

  logic signed [WIDTH-1:0] x_0;
  logic signed [WIDTH-1:0] y_0;
  logic signed [WIDTH-1:0] z_0;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output x_0, y_0, z_0, out_valid,
    input  out_ready
  );

  modport slave (
    input  x_0, y_0, z_0, out_valid,
    output out_ready
  );

endinterface

// File: rtl/nco_rate_divider.sv
// Sample-rate divider: one tick every rate_div+1 enabled cycles.
module nco_rate_divider
  import nco_pkg::*;
#(
  parameter int DIV_WIDTH = NCO_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sync_clr,
  input  logic [DIV_WIDTH-1:0] rate_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_cnt_q;
  logic [DIV_WIDTH-1:0] div_cnt_d;

  // >= so that lowering rate_div below the running count ticks at once.
  always_comb begin
    tick      = enable && !sync_clr && (div_cnt_q >= rate_div);
    div_cnt_d = div_cnt_q;
    if (sync_clr) begin
      div_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d = '0;
    end else if (enable) begin
      div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/cordic_nco_source.sv
// Phase-accumulator NCO producing CORDIC x_0/y_0/z_0 with shadowed FTW/offset.
module cordic_nco_source
  import nco_pkg::*;
#(
  parameter int               WIDTH     = NCO_WIDTH,
  parameter logic [WIDTH-1:0] X_INIT    = WIDTH'(NCO_X_INIT),
  parameter int               DIV_WIDTH = NCO_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      ftw_in,
  input  logic                  ftw_we,
  input  logic [WIDTH-1:0]      pofs_in,
  input  logic                  pofs_we,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  input  logic                  enable,
  input  logic                  sync_clr,
  cordic_nco_source_if.master   out_if,
  output logic                  overrun
);

  logic             tick;
  logic             slot_free;
  logic [WIDTH-1:0] sample_phase;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] ftw_shadow_q, ftw_shadow_d;
  logic [WIDTH-1:0] pofs_shadow_q, pofs_shadow_d;
  logic [WIDTH-1:0] x_0_q, x_0_d;
  logic [WIDTH-1:0] y_0_q, y_0_d;
  logic [WIDTH-1:0] z_0_q, z_0_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  nco_rate_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_divider (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .sync_clr (sync_clr),
    .rate_div (rate_div),
    .tick     (tick)
  );

  // Ticks read the shadows as they were before this edge's writes land.
  assign sample_phase = acc_q + pofs_shadow_q;
  assign slot_free    = !out_valid_q || out_if.out_ready;

  always_comb begin
    acc_d         = acc_q;
    ftw_shadow_d  = ftw_we  ? ftw_in  : ftw_shadow_q;
    pofs_shadow_d = pofs_we ? pofs_in : pofs_shadow_q;
    x_0_d         = x_0_q;
    y_0_d         = y_0_q;
    z_0_d         = z_0_q;
    out_valid_d   = out_valid_q;
    overrun_d     = overrun_q;
    if (sync_clr) begin
      acc_d       = '0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else if (tick) begin
      acc_d = acc_q + ftw_shadow_q;
      if (slot_free) begin
        x_0_d       = X_INIT;
        y_0_d       = '0;
        z_0_d       = sample_phase;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      ftw_shadow_q  <= '0;
      pofs_shadow_q <= '0;
      x_0_q         <= '0;
      y_0_q         <= '0;
      z_0_q         <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      ftw_shadow_q  <= ftw_shadow_d;
      pofs_shadow_q <= pofs_shadow_d;
      x_0_q         <= x_0_d;
      y_0_q         <= y_0_d;
      z_0_q         <= z_0_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_if.x_0       = $signed(x_0_q);
  assign out_if.y_0       = $signed(y_0_q);
  assign out_if.z_0       = $signed(z_0_q);
  assign out_if.out_valid = out_valid_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_cordic_nco_source.sv
// Directed bench for cordic_nco_source: per-cycle model compare plus literal sample sequences.
module tb_cordic_nco_source;
  import nco_pkg::*;

  localparam logic [31:0] XI = 32'h26DD3B6A;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ftw_in, pofs_in;
  logic        ftw_we, pofs_we;
  logic [15:0] rate_div;
  logic        enable, sync_clr, out_ready;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic cmp_on = 1'b0;

  always #5 clk = ~clk;

  cordic_nco_source_if #(.WIDTH(32)) nco_if ();
  assign nco_if.out_ready = out_ready;

  cordic_nco_source #(
    .WIDTH     (32),
    .X_INIT    (XI),
    .DIV_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ftw_in   (ftw_in),
    .ftw_we   (ftw_we),
    .pofs_in  (pofs_in),
    .pofs_we  (pofs_we),
    .rate_div (rate_div),
    .enable   (enable),
    .sync_clr (sync_clr),
    .out_if   (nco_if.master),
    .overrun  (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: phase = running sum of steps, sample = phase + offset.
  logic [31:0] m_acc = '0, m_ftw = '0, m_pofs = '0;
  int          m_cnt = 0;
  logic        m_valid = 1'b0, m_ovr = 1'b0;
  logic [31:0] m_x = '0, m_y = '0, m_z = '0;
  logic        m_tick;
  assign m_tick = enable && !sync_clr && (m_cnt >= int'(rate_div));

  always @(posedge clk) begin
    if (rst) begin
      m_acc <= '0; m_ftw <= '0; m_pofs <= '0; m_cnt <= 0;
      m_valid <= 1'b0; m_ovr <= 1'b0; m_x <= '0; m_y <= '0; m_z <= '0;
    end else begin
      if (ftw_we)  m_ftw  <= ftw_in;
      if (pofs_we) m_pofs <= pofs_in;
      if (sync_clr) begin
        m_acc <= '0; m_cnt <= 0; m_valid <= 1'b0; m_ovr <= 1'b0;
      end else begin
        if (enable) m_cnt <= m_tick ? 0 : m_cnt + 1;
        if (m_tick) begin
          m_acc <= m_acc + m_ftw;
          if (!m_valid || out_ready) begin
            m_z <= m_acc + m_pofs; m_x <= XI; m_y <= '0; m_valid <= 1'b1;
          end else begin
            m_ovr <= 1'b1;
          end
        end else if (out_ready) begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  logic [31:0] cap_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("valid",   {31'd0, nco_if.out_valid}, {31'd0, m_valid});
      chk("overrun", {31'd0, overrun},          {31'd0, m_ovr});
      chk("x_0", nco_if.x_0, m_x);
      chk("y_0", nco_if.y_0, m_y);
      chk("z_0", nco_if.z_0, m_z);
      if (nco_if.out_valid && out_ready) cap_q.push_back(nco_if.z_0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input string name);
    chk({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk(name, cap_q[i], exp_q[i]);
    cap_q.delete();
  endtask

  task automatic write_regs(input logic [31:0] f, input logic [31:0] p);
    ftw_in = f; pofs_in = p; ftw_we = 1'b1; pofs_we = 1'b1;
    cyc(1);
    ftw_we = 1'b0; pofs_we = 1'b0;
  endtask

  task automatic clear_phase();
    sync_clr = 1'b1;
    cyc(1);
    sync_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ftw_in = '0; pofs_in = '0; ftw_we = 1'b0; pofs_we = 1'b0;
    rate_div = '0; enable = 1'b0; sync_clr = 1'b0; out_ready = 1'b1;
    cyc(2);
    cmp_on = 1'b1;
    rst = 1'b0;
    chk("rst_valid", {31'd0, nco_if.out_valid}, 32'd0);
    chk("rst_z", nco_if.z_0, 32'd0);
    chk("rst_x", nco_if.x_0, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);

    // Quarter-turn steps, one sample per clock.
    write_regs(32'h4000_0000, 32'h0);
    enable = 1'b1;
    cyc(1);
    chk("first_valid", {31'd0, nco_if.out_valid}, 32'd1);
    chk("first_x", nco_if.x_0, XI);
    chk("first_y", nco_if.y_0, 32'd0);
    cyc(1);
    chk("quadrant", {30'd0, quadrant_of(nco_if.z_0)}, {30'd0, QUAD_POS_HALF_PI});
    cyc(3);
    enable = 1'b0;
    cyc(2);
    exp_q = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
    expect_seq("quarter_seq");

    // Divide by 4, then lower rate_div mid-count.
    clear_phase();
    rate_div = 16'd3;
    write_regs(32'h1, 32'h0);
    enable = 1'b1;
    cyc(4);
    chk("div4_tick", {31'd0, nco_if.out_valid}, 32'd1);
    cyc(10);
    chk("div_mid_idle", {31'd0, nco_if.out_valid}, 32'd0);
    rate_div = 16'd1;
    cyc(1);
    chk("div_reduce_tick", nco_if.z_0, 32'd3);
    cyc(2);
    chk("div2_tick", nco_if.z_0, 32'd4);
    enable = 1'b0;
    cyc(2);
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    expect_seq("div_seq");

    // Offset applies to the same tick's successor; FTW changes the step after.
    clear_phase();
    rate_div = 16'd0;
    write_regs(32'h10, 32'h0);
    enable = 1'b1;
    cyc(2);
    pofs_in = 32'h8000_0000; pofs_we = 1'b1;
    cyc(1);
    pofs_we = 1'b0;
    cyc(1);
    ftw_in = 32'h30; ftw_we = 1'b1;
    cyc(1);
    ftw_we = 1'b0;
    cyc(2);
    enable = 1'b0;
    cyc(2);
    exp_q = '{32'h0, 32'h10, 32'h20, 32'h8000_0030, 32'h8000_0040,
              32'h8000_0050, 32'h8000_0080};
    expect_seq("pofs_seq");

    // Stall for three ticks.
    clear_phase();
    write_regs(32'h1, 32'h0);
    out_ready = 1'b0;
    enable = 1'b1;
    cyc(1);
    chk("stall_first_z", nco_if.z_0, 32'd0);
    cyc(3);
    chk("stall_hold_z", nco_if.z_0, 32'd0);
    chk("stall_valid", {31'd0, nco_if.out_valid}, 32'd1);
    chk("stall_ovr", {31'd0, overrun}, 32'd1);
    out_ready = 1'b1;
    cyc(1);
    chk("stall_resume_z", nco_if.z_0, 32'd4);
    enable = 1'b0;
    cyc(2);
    exp_q = '{32'd0, 32'd4};
    expect_seq("stall_seq");

    // sync_clr on a tick edge.
    write_regs(32'h1, 32'h100);
    enable = 1'b1;
    cyc(2);
    chk("pre_clr_ovr", {31'd0, overrun}, 32'd1);
    sync_clr = 1'b1;
    cyc(1);
    sync_clr = 1'b0;
    chk("clr_valid", {31'd0, nco_if.out_valid}, 32'd0);
    chk("clr_ovr", {31'd0, overrun}, 32'd0);
    cyc(1);
    chk("clr_first_z", nco_if.z_0, 32'h100);
    cyc(1);
    chk("clr_second_z", nco_if.z_0, 32'h101);
    enable = 1'b0;
    cyc(2);
    cap_q.delete();

    // Half-turn step alternates 0 and pi.
    clear_phase();
    write_regs(32'h8000_0000, 32'h0);
    enable = 1'b1;
    cyc(3);
    enable = 1'b0;
    cyc(2);
    exp_q = '{32'h0, 32'h8000_0000, 32'h0};
    expect_seq("halfturn_seq");

    // Reset while a sample is pending and writes are in flight.
    out_ready = 1'b0;
    enable = 1'b1;
    cyc(1);
    chk("pre_rst_valid", {31'd0, nco_if.out_valid}, 32'd1);
    rst = 1'b1; ftw_in = 32'h1234; pofs_in = 32'h55; ftw_we = 1'b1; pofs_we = 1'b1;
    cyc(1);
    chk("rst_mid_valid", {31'd0, nco_if.out_valid}, 32'd0);
    chk("rst_mid_z", nco_if.z_0, 32'd0);
    chk("rst_mid_x", nco_if.x_0, 32'd0);
    rst = 1'b0; ftw_we = 1'b0; pofs_we = 1'b0; out_ready = 1'b1;
    cyc(1);
    chk("post_rst_valid", {31'd0, nco_if.out_valid}, 32'd1);
    chk("post_rst_z", nco_if.z_0, 32'd0);
    enable = 1'b0;
    cyc(2);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
